stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

- Controller for the 60-second timer.
- Sequences a four-digit BCD stopwatch value (SS.hh, 00.00 to 60.00) from one-cycle start/stop/clear command pulses.
- Drives the four digit inputs of the seven-segment display driver, plus status and per-digit blanking outputs.
- Sits between the debounced push-button logic and the display driver.

## Interface

Parameters:
- TICK_DIV, default 1_000_000: clock cycles per 0.01 s tick (100 MHz clock); must be ≥ 2.
- BLINK_DIV, default 25_000_000: clock cycles per blink half-period; used only with TIMER_DONE_BLINK_EN.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle command pulse, synchronous to clk.
- stop  in  1  one-cycle command pulse.
- clear  in  1  one-cycle command pulse.
- disp3  out  4  seconds tens digit, BCD 0–6.
- disp2  out  4  seconds ones digit, BCD 0–9.
- disp1  out  4  tenths digit, BCD 0–9.
- disp0  out  4  hundredths digit, BCD 0–9.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- blank  out  4  per-digit blank request, 1 = digit off; bit i maps to disp i.

## Operation

States:
- IDLE: value 00.00.
- RUN: counting.
- PAUSE: value held.
- DONE: value 60.00.

Command priority within a cycle: clear > stop > start. Transitions:
- IDLE: start → RUN; stop/clear ignored.
- RUN: clear → IDLE (value 00.00); stop → PAUSE; tick at value 59.99 → DONE with value 60.00.
- PAUSE: clear → IDLE; start → RUN.
- DONE: clear → IDLE; start/stop ignored.

Prescaler:
- Counts 0..TICK_DIV-1, incrementing only in RUN.
- tick = (prescaler == TICK_DIV-1) in RUN; the prescaler wraps to 0 on tick.
- Held in PAUSE, so the sub-tick phase is preserved across pause/resume.
- Forced to 0 in IDLE and DONE.

BCD increment on tick:
- disp0 +1; at 9 it wraps to 0 with carry into disp1.
- disp1 and disp2 behave the same way, each carrying into the next digit.
- disp3 is 0–5 during counting. A carry out of 59.99 does not wrap: it loads 6,0,0,0 and enters DONE.

Simultaneous events:
- stop and tick in the same RUN cycle: the tick is applied, then the state moves to PAUSE.
- clear and tick: clear wins and the value becomes 00.00.
- Reset mid-count: asynchronous return to IDLE. No value is retained.

## Timing

- All outputs are registered.
- Reset values: disp3..disp0 = 0, running = 0, done = 0, blank = 4'b0000; state IDLE, prescaler 0, blink counter 0.
- start sampled at edge N (from IDLE): running = 1 after edge N; prescaler = 0 at that point.
- First tick is asserted TICK_DIV cycles after entering RUN from IDLE; disp0 shows 1 one edge after that tick.
- Subsequent ticks follow every TICK_DIV cycles.
- stop at edge N: running = 0 after edge N; no further increments.
- Final tick at 59.99: after the same edge, done = 1, running = 0, and the display shows 60.00.
- Full run from IDLE to DONE: exactly 6000 × TICK_DIV cycles of RUN.
- clear at edge N: digits 0, done = 0, running = 0 after edge N.

## Configuration

TIMER_DONE_BLINK_EN defined:
- In DONE, a blink counter counts 0..BLINK_DIV-1.
- At each wrap, blank toggles between 4'b1111 and 4'b0000.
- blank is 4'b1111 for the first BLINK_DIV cycles after entering DONE, starting on the edge that enters DONE.
- Outside DONE, blank = 4'b0000 and the blink counter is 0.

TIMER_DONE_BLINK_EN undefined:
- No blink counter is implemented.
- blank is tied to 4'b0000.
- BLINK_DIV is unused.

## Structure

- Shared package timer_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
  - BCD constants (digit max 9, seconds-tens max 5, final-value tens digit 6).
- One sub-module, bcd_digit: 4-bit counter with parameter MAX, inputs en and clr, outputs q and carry (carry = en & q==MAX).
  - Instantiate it for disp0..disp2 with MAX=9.
  - disp3 is handled in the top because of the 60.00 load.
- Top module holds the FSM, prescaler and optional blink counter.

## Test plan

Bench uses TICK_DIV=4, BLINK_DIV=3.

1. Reset held low, then released:
   - all outputs 0, state IDLE;
   - stop/clear pulses leave disp at 0000.
2. start pulse, then wait 40 cycles → disp = 0,0,1,0 (00.10); running = 1.
3. After 12.34, pulse stop and wait 20 cycles, then pulse start:
   - value holds at 12.34 during the pause;
   - after resume, the next increment occurs after the remaining prescaler phase, not a full TICK_DIV.
4. Run from IDLE for 6000×4 cycles:
   - the 59.99 → 60.00 transition occurs with done = 1 and running = 0;
   - further start pulses leave the value at 60.00.
5. Blink behaviour in DONE:
   - with TIMER_DONE_BLINK_EN defined, blank toggles 1111/0000 every 3 cycles;
   - without it, blank stays 0000.
   - clear → 00.00, done = 0, blank = 0000 the next cycle.
6. Simultaneous commands and reset:
   - start+stop+clear in one cycle during RUN → IDLE, 00.00;
   - stop coinciding with a tick → increment applied, then PAUSE;
   - rst asserted mid-run → outputs 0 asynchronously.

Source files
------------

// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the 60-second stopwatch controller:
//   state_e         - controller state encoding (IDLE/RUN/PAUSE/DONE)
//   DIGIT_MAX       - largest value of a plain BCD digit
//   SEC_TENS_MAX    - largest seconds-tens digit while counting
//   SEC_TENS_FINAL  - seconds-tens digit of the terminal value 60.00
// ----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] DIGIT_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX   = 4'd5;
    localparam logic [3:0] SEC_TENS_FINAL = 4'd6;

endpackage

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
// One wrapping BCD counter digit, 0..MAX.
// Ports:
//   clk   in   clock (rising edge)
//   rst   in   asynchronous active-low reset
//   en    in   increment request (carry in)
//   clr   in   synchronous clear, takes priority over en
//   q     out  current digit value
//   carry out  en & (q == MAX): this digit wraps on the current edge
// ----------------------------------------------------------------------------
module bcd_digit
    import timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en & (q_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
// Controller for the 60-second timer. Counts SS.hh from 00.00 to 60.00 in
// 0.01 s ticks under start/stop/clear command pulses (priority
// clear > stop > start) and drives the four display digits.
// Optional feature macro: TIMER_DONE_BLINK_EN - blink all digits in DONE.
// Parameters:
//   TICK_DIV   clock cycles per 0.01 s tick (>= 2)
//   BLINK_DIV  clock cycles per blink half-period (blink build only)
// Ports:
//   clk                  in   clock (rising edge)
//   rst                  in   asynchronous active-low reset
//   start/stop/clear     in   one-cycle command pulses
//   disp3..disp0         out  BCD digits: seconds tens/ones, tenths, hundredths
//   running              out  high in RUN
//   done                 out  high in DONE
//   blank                out  per-digit blank request (bit i -> disp i)
// ----------------------------------------------------------------------------
module stopwatch_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       running,
    output logic       done,
    output logic [3:0] blank
);

    localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

    state_e         state_q;
    logic           running_q;
    logic           done_q;
    logic [PW-1:0]  presc_q;
    logic [PW-1:0]  presc_d;
    logic [3:0]     d3_q;
    logic [3:0]     d3_d;

    logic tick;
    logic c0, c1, c2;
    logic final_tick;
    logic cmd_start;

    // Commands reduced by priority; stop only matters in RUN, where clear is
    // checked first anyway.
    assign cmd_start  = start & ~stop & ~clear;

    assign tick       = (state_q == ST_RUN) && (presc_q == TICK_LAST);
    // Carry out of 59.99: the lower three digits wrap to 0 by themselves,
    // only the tens digit needs the special load of 6.
    assign final_tick = c2 && (d3_q == SEC_TENS_MAX);

    // ---------------- prescaler ----------------
    always_comb begin
        presc_d = '0;
        unique case (state_q)
            ST_RUN:   presc_d = (clear || tick) ? '0 : presc_q + PW'(1);
            ST_PAUSE: presc_d = clear ? '0 : presc_q;
            default:  presc_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ---------------- BCD digits ----------------
    bcd_digit #(.MAX(DIGIT_MAX)) u_d0 (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .clr   (clear),
        .q     (disp0),
        .carry (c0)
    );

    bcd_digit #(.MAX(DIGIT_MAX)) u_d1 (
        .clk   (clk),
        .rst   (rst),
        .en    (c0),
        .clr   (clear),
        .q     (disp1),
        .carry (c1)
    );

    bcd_digit #(.MAX(DIGIT_MAX)) u_d2 (
        .clk   (clk),
        .rst   (rst),
        .en    (c1),
        .clr   (clear),
        .q     (disp2),
        .carry (c2)
    );

    always_comb begin
        d3_d = d3_q;
        if (clear) begin
            d3_d = '0;
        end else if (final_tick) begin
            d3_d = SEC_TENS_FINAL;
        end else if (c2) begin
            d3_d = d3_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d3_q <= '0;
        end else begin
            d3_q <= d3_d;
        end
    end

    assign disp3 = d3_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (final_tick) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (stop) begin
                        // A tick on this edge is still applied by the digits.
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (clear) begin
                        state_q <= ST_IDLE;
                    end else if (cmd_start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign running = running_q;
    assign done    = done_q;

    // ---------------- optional blink ----------------
`ifdef TIMER_DONE_BLINK_EN
    localparam int unsigned   BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q;
    logic [3:0]    blank_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blank_q     <= '0;
        end else if (state_q == ST_DONE) begin
            if (clear) begin
                blink_cnt_q <= '0;
                blank_q     <= '0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blank_q     <= ~blank_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end else if ((state_q == ST_RUN) && final_tick && !clear) begin
            // Blank phase starts on the very edge that enters DONE.
            blink_cnt_q <= '0;
            blank_q     <= '1;
        end else begin
            blink_cnt_q <= '0;
            blank_q     <= '0;
        end
    end

    assign blank = blank_q;
`else
    logic unused_blink_div;
    assign unused_blink_div = |BLINK_DIV;
    assign blank = '0;
`endif

endmodule
